// File: rtl/seg7_pkg.sv
// Shared segment-code definitions for the 7-segment display path.
// Codes are {g,f,e,d,c,b,a}, 1 = segment lit; all-zero is the reset/invalid code.
package seg7_pkg;
   localparam int SEG_W      = 7;
   localparam int NUM_DIGITS = 3;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t DIGI_0 = 7'h3F;
   localparam seg_t DIGI_1 = 7'h06;
   localparam seg_t DIGI_2 = 7'h5B;
   localparam seg_t DIGI_3 = 7'h4F;
   localparam seg_t DIGI_4 = 7'h66;
   localparam seg_t DIGI_5 = 7'h6D;
   localparam seg_t DIGI_6 = 7'h7D;
   localparam seg_t DIGI_7 = 7'h07;
   localparam seg_t DIGI_8 = 7'h7F;
   localparam seg_t DIGI_9 = 7'h6F;
   localparam seg_t DIGI_X = 7'h00;
endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit index for the display scan; produces the dead-time
// phase flag and the once-per-frame snapshot strobe.
module seg7_scan_timer
   import seg7_pkg::*;
#(
   parameter int SLOT_CYCLES = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic       clock,
   input  logic       rst,
   output logic [1:0] idx,
   output logic       in_dead,
   output logic       snap
);
   localparam int            CW      = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_W  = CW'(DEAD_CYCLES);
   localparam logic [1:0]    IDX_MAX = 2'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;

   // NOTE: next-state defaults are assigned first so no path leaves a signal unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? 2'd0 : idx_q + 2'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments only; combinational logic uses blocking.
   always_ff @(posedge clock) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx     = idx_q;
   assign in_dead = (cnt_q < DEAD_W);
   assign snap    = (cnt_q == '0) && (idx_q == 2'd0);
endmodule

// File: rtl/seg7_scan_3digit.sv
// Time-multiplexed 3-digit 7-segment driver with per-frame input snapshot.
// Define SEG7_BLANK_LZ_EN to suppress leading zeros on digits 2 and 1.
module seg7_scan_3digit
   import seg7_pkg::*;
#(
   parameter int SLOT_CYCLES = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [SEG_W-1:0]      digi_2,
   input  logic [SEG_W-1:0]      digi_1,
   input  logic [SEG_W-1:0]      digi_0,
   input  logic                  blank,
   output logic [SEG_W-1:0]      seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_start
);
   logic [1:0] idx;
   logic       in_dead;
   logic       snap;

   seg7_scan_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_timer (
      .clock   (clock),
      .rst     (rst),
      .idx     (idx),
      .in_dead (in_dead),
      .snap    (snap)
   );

   seg_t                  shadow_q [NUM_DIGITS];
   seg_t                  shadow_d [NUM_DIGITS];
   seg_t                  seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0] suppress;

`ifdef SEG7_BLANK_LZ_EN
   logic sup_2, sup_1;
   assign sup_2    = (shadow_q[2] == DIGI_0);
   assign sup_1    = sup_2 && (shadow_q[1] == DIGI_0);
   assign suppress = {sup_2, sup_1, 1'b0};
`else
   assign suppress = '0;
`endif

   always_comb begin
      shadow_d = shadow_q;
      if (snap) begin
         shadow_d[0] = digi_0;
         shadow_d[1] = digi_1;
         shadow_d[2] = digi_2;
      end
   end

   always_comb begin
      an_d          = '0;
      seg_d         = '0;
      frame_start_d = snap;
      if (!in_dead && !blank && !suppress[idx]) begin
         an_d  = NUM_DIGITS'(1) << idx;
         seg_d = shadow_q[idx];
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         // NOTE: the shadow array is reset explicitly so a display can never show an undefined code.
         shadow_q      <= '{default: '0};
         an_q          <= '0;
         seg_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_3digit.sv
// Scoreboard bench for seg7_scan_3digit: a cycle-count reference model queues
// the expected outputs per cycle; a monitor compares on the falling edge.
module tb_seg7_scan_3digit;
   import seg7_pkg::*;

   localparam int SLOT  = 8;
   localparam int DEAD  = 2;
   localparam int FRAME = NUM_DIGITS * SLOT;

   logic       clock = 1'b0;
   logic       rst;
   logic       blank;
   logic [6:0] digi_2, digi_1, digi_0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame_start;

   always #5 clock = ~clock;

   seg7_scan_3digit #(
      .SLOT_CYCLES (SLOT),
      .DEAD_CYCLES (DEAD)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .digi_2      (digi_2),
      .digi_1      (digi_1),
      .digi_0      (digi_0),
      .blank       (blank),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   typedef struct packed {
      logic [2:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // stimulus values for the cycle being driven
   logic       r_v, b_v;
   logic [6:0] d_v [3];

   // reference model state: index of current cycle since reset release, latched frame values
   int         m = 0;
   logic [6:0] frame_val [3];

`ifdef SEG7_BLANK_LZ_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   // A non-units digit is a leading zero when it and every higher digit show zero.
   function automatic bit is_leading_zero(input int k);
      bit all_zero = 1'b1;
      if (!LZ_EN || k == 0) return 1'b0;
      for (int j = k; j < NUM_DIGITS; j++)
         if (frame_val[j] != DIGI_0) all_zero = 1'b0;
      return all_zero;
   endfunction

   task automatic model_edge(input logic r, input logic [6:0] a2, a1, a0, input logic b);
      exp_t e;
      int   pos, slot, off;
      bit   dark;
      e = '0;
      if (r) begin
         m = 0;
      end else begin
         pos  = m % FRAME;
         if (pos == 0) begin
            frame_val[0] = a0;
            frame_val[1] = a1;
            frame_val[2] = a2;
         end
         slot = pos / SLOT;
         off  = pos % SLOT;
         dark = (off < DEAD) || b || is_leading_zero(slot);
         e.fs  = (pos == 0);
         e.an  = dark ? 3'b000 : 3'(1 << slot);
         e.seg = dark ? 7'h00 : frame_val[slot];
         m++;
      end
      sb.push_back(e);
   endtask

   task automatic tick();
      rst    = r_v;
      blank  = b_v;
      digi_0 = d_v[0];
      digi_1 = d_v[1];
      digi_2 = d_v[2];
      @(posedge clock);
      #1;
      cyc++;
      model_edge(r_v, d_v[2], d_v[1], d_v[0], b_v);
   endtask

   task automatic run_to(input int pos);
      while (m % FRAME != pos) tick();
   endtask

   task automatic set_digits(input logic [6:0] a2, a1, a0);
      d_v[2] = a2;
      d_v[1] = a1;
      d_v[0] = a0;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
   endtask

   function automatic logic [6:0] rand_code();
      logic [6:0] tbl [11];
      tbl = '{DIGI_0, DIGI_1, DIGI_2, DIGI_3, DIGI_4, DIGI_5,
              DIGI_6, DIGI_7, DIGI_8, DIGI_9, DIGI_X};
      if ($urandom_range(0, 7) == 0) return 7'($urandom);
      return tbl[$urandom_range(0, 10)];
   endfunction

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("an", 16'(an), 16'(e.an));
            check("seg", 16'(seg), 16'(e.seg));
            check("frame_start", 16'(frame_start), 16'(e.fs));
         end
      end
   end

   initial begin
      int blank_left;
      int guard;

      // reset held with non-zero inputs
      r_v = 1'b1;
      b_v = 1'b0;
      set_digits(DIGI_8, DIGI_8, DIGI_8);
      repeat (3) tick();

      // static 123
      r_v = 1'b0;
      set_digits(DIGI_1, DIGI_2, DIGI_3);
      repeat (2 * FRAME) tick();

      // mid-frame change of the units digit
      run_to(5);
      d_v[0] = DIGI_9;
      repeat (2 * FRAME) tick();

      // leading-zero patterns
      run_to(0);
      set_digits(DIGI_0, DIGI_0, DIGI_7);
      repeat (2 * FRAME) tick();
      set_digits(DIGI_1, DIGI_0, DIGI_5);
      repeat (2 * FRAME) tick();
      set_digits(DIGI_0, DIGI_4, DIGI_X);
      repeat (2 * FRAME) tick();

      // blank for 10 cycles mid-frame
      set_digits(DIGI_4, DIGI_5, DIGI_6);
      run_to(10);
      b_v = 1'b1;
      repeat (10) tick();
      b_v = 1'b0;
      repeat (2 * FRAME) tick();

      // reset pulse mid-slot
      run_to(13);
      r_v = 1'b1;
      tick();
      r_v = 1'b0;
      set_digits(DIGI_7, DIGI_8, DIGI_9);
      repeat (2 * FRAME) tick();

      // randomized run
      blank_left = 0;
      repeat (600) begin
         if ($urandom_range(0, 19) == 0) d_v[$urandom_range(0, 2)] = rand_code();
         if (blank_left == 0 && $urandom_range(0, 59) == 0) blank_left = $urandom_range(1, 12);
         b_v = (blank_left != 0);
         if (blank_left != 0) blank_left--;
         r_v = ($urandom_range(0, 249) == 0);
         tick();
      end
      r_v = 1'b0;
      b_v = 1'b0;
      tick();

      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         @(negedge clock);
         #1;
         guard++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
